// File: rtl/am_sched_pkg.sv
// Shared types and sizes for the amplitude-modulator voice scheduler.
package am_sched_pkg;

  localparam int unsigned NUM_VOICES  = 3;
  localparam int unsigned WAVE_W      = 12;
  localparam int unsigned ENV_W       = 8;
  localparam int unsigned MIX_W_DEF   = 14;
  localparam int unsigned IDX_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // Travels alongside a multiplier operand pair so the result can be routed back.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/am_sched_tag_pipe.sv
// Fixed-depth shift register that delays issue tags to line up with multiplier results.
module am_sched_tag_pipe
  import am_sched_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe_q [Depth];

  // Shift tags one stage per cycle; reset drops any in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_out = pipe_q[Depth-1];

endmodule

// File: rtl/am_voice_scheduler.sv
// Time-multiplexes one shared wave x envelope multiplier across all voices per sample tick.
module am_voice_scheduler
  import am_sched_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned MIX_W       = MIX_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [NUM_VOICES*WAVE_W-1:0]   wave_in,
  input  logic [NUM_VOICES*ENV_W-1:0]    env_in,
  output logic signed [WAVE_W-1:0]       mul_wave,
  output logic [ENV_W-1:0]               mul_env,
  input  logic signed [WAVE_W-1:0]       mul_result,
  output logic [NUM_VOICES*WAVE_W-1:0]   voice_out,
  output logic signed [MIX_W-1:0]        mix_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun,
  input  logic                           overrun_clr
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_VOICES - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [MIX_W-1:0]  acc_q, acc_d;
  logic signed [MIX_W-1:0]  mix_q;
  logic                     overrun_q;
  logic                     load_snap, load_out;
  tag_t                     tag_in, tag_out;

  logic [WAVE_W-1:0]        snap_wave_q [NUM_VOICES];
  logic [ENV_W-1:0]         snap_env_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0]    snap_en_q;
  logic [WAVE_W-1:0]        vnext_q     [NUM_VOICES];
  logic [WAVE_W-1:0]        vnext_d     [NUM_VOICES];
  logic [WAVE_W-1:0]        vout_q      [NUM_VOICES];

  am_sched_tag_pipe #(
    .Depth (MUL_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Next-state, issue operands and result capture.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    vnext_d   = vnext_q;
    load_snap = 1'b0;
    load_out  = 1'b0;
    tag_in    = '0;
    mul_wave  = '0;
    mul_env   = '0;

    // mul_result is junk unless a valid tag accompanies it.
    if (tag_out.valid) begin
      vnext_d[tag_out.idx] = mul_result;
      acc_d = acc_q + {{(MIX_W-WAVE_W){mul_result[WAVE_W-1]}}, mul_result};
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (sample_tick) begin
          load_snap = 1'b1;
          state_d   = StIssue;
          idx_d     = '0;
          acc_d     = '0;
        end else begin
          state_d   = StIdle;
        end
      end
      StIssue: begin
        mul_wave = snap_wave_q[idx_q];
        mul_env  = snap_en_q[idx_q] ? snap_env_q[idx_q] : '0;
        tag_in   = '{valid: 1'b1, idx: idx_q};
        idx_d    = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = StDrain;
      end
      StDrain: begin
        if (tag_out.valid && tag_out.idx == LastIdx) begin
          state_d  = StDone;
          load_out = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control, accumulator, overrun flag and mix register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      overrun_q <= 1'b0;
      snap_en_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      if (load_out) mix_q <= acc_d;
      // A new overrun event wins over a simultaneous clear.
      if (sample_tick && busy) overrun_q <= 1'b1;
      else if (overrun_clr)    overrun_q <= 1'b0;
      if (load_snap) snap_en_q <= voice_en;
    end
  end

  // Per-voice snapshot, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        snap_wave_q[i] <= '0;
        snap_env_q[i]  <= '0;
        vnext_q[i]     <= '0;
        vout_q[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnext_q[i] <= vnext_d[i];
        if (load_snap) begin
          snap_wave_q[i] <= wave_in[i*WAVE_W +: WAVE_W];
          snap_env_q[i]  <= env_in[i*ENV_W +: ENV_W];
        end
        if (load_out) vout_q[i] <= vnext_d[i];
      end
    end
  end

  // Flatten per-voice results onto the output bus.
  always_comb begin
    voice_out = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_out[i*WAVE_W +: WAVE_W] = vout_q[i];
  end

  assign mix_out   = mix_q;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StIssue) || (state_q == StDrain);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_am_voice_scheduler.sv
// Directed bench for am_voice_scheduler with a 1-cycle behavioural multiplier.
module tb_am_voice_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [2:0]  voice_en;
  logic [35:0] wave_in;
  logic [23:0] env_in;
  logic signed [11:0] mul_wave;
  logic [7:0]  mul_env;
  logic signed [11:0] mul_result;
  logic [35:0] voice_out;
  logic signed [13:0] mix_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        overrun_clr;

  int n_checks = 0;
  int n_pass   = 0;

  am_voice_scheduler #(
    .MUL_LATENCY (1),
    .MIX_W       (14)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .wave_in     (wave_in),
    .env_in      (env_in),
    .mul_wave    (mul_wave),
    .mul_env     (mul_env),
    .mul_result  (mul_result),
    .voice_out   (voice_out),
    .mix_out     (mix_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  // Shared multiplier model: one register stage, no reset.
  always @(posedge clk) mul_result <= 12'((int'(mul_wave) * int'(mul_env)) >>> 8);

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int vout(input int i);
    logic signed [11:0] v;
    v = voice_out[i*12 +: 12];
    return int'(v);
  endfunction

  task automatic set_voice(input int i, input int w, input int e);
    wave_in[i*12 +: 12] = 12'(w);
    env_in[i*8 +: 8]    = 8'(e);
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic(input logic [2:0] en);
    set_voice(0, 100, 255);
    set_voice(1, -200, 128);
    set_voice(2, 2047, 0);
    voice_en = en;
  endtask

  // Caller has raised sample_tick in cycle 0; walk cycles 1..6.
  task automatic run_frame(input string name, input int w0, input int w1, input int w2,
                           input int e0, input int e1, input int e2);
    int ew[3];
    int ee[3];
    ew = '{w0, w1, w2};
    ee = '{e0, e1, e2};
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      sample_tick = 1'b0;
      if (c <= 3) begin
        check({name, " mul_wave"}, int'(mul_wave), ew[c-1]);
        check({name, " mul_env"}, int'(mul_env), ee[c-1]);
      end
      check({name, " busy"}, int'(busy), (c <= 4) ? 1 : 0);
      check({name, " out_valid"}, int'(out_valid), (c == 5) ? 1 : 0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    sample_tick = 1'b1;
    overrun_clr = 1'b0;
    voice_en    = 3'($urandom);
    wave_in     = {$urandom, $urandom};
    env_in      = 24'($urandom);
    #1;
    repeat (2) next_cycle();
    check("rst voice_out", int'(voice_out != '0), 0);
    check("rst mix_out", int'(mix_out), 0);
    check("rst busy", int'(busy), 0);
    check("rst out_valid", int'(out_valid), 0);
    check("rst mul_env", int'(mul_env), 0);
    check("rst overrun", int'(overrun), 0);
    sample_tick = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      check("post-rst out_valid", int'(out_valid), 0);
    end

    // Full enable.
    load_basic(3'b111);
    sample_tick = 1'b1;
    run_frame("en111", 100, -200, 2047, 255, 128, 0);
    check("en111 v0", vout(0), 99);
    check("en111 v1", vout(1), -100);
    check("en111 v2", vout(2), 0);
    check("en111 mix", int'(mix_out), -1);

    // Only voice 1 enabled; schedule length unchanged.
    next_cycle();
    load_basic(3'b010);
    sample_tick = 1'b1;
    run_frame("en010", 100, -200, 2047, 0, 128, 0);
    check("en010 v0", vout(0), 0);
    check("en010 v1", vout(1), -100);
    check("en010 v2", vout(2), 0);
    check("en010 mix", int'(mix_out), -100);

    // Overrun: extra tick in cycle 2 with changed inputs.
    next_cycle();
    load_basic(3'b111);
    sample_tick = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      sample_tick = 1'b0;
      overrun_clr = 1'b0;
      if (c == 2) begin
        sample_tick = 1'b1;
        set_voice(0, 500, 200);
        set_voice(2, -7, 255);
        voice_en = 3'b000;
      end
      if (c >= 3) check("ovr flag", int'(overrun), (c <= 6) ? 1 : 0);
      check("ovr out_valid", int'(out_valid), (c == 5) ? 1 : 0);
      if (c == 5) begin
        check("ovr v0", vout(0), 99);
        check("ovr v2", vout(2), 0);
        check("ovr mix", int'(mix_out), -1);
      end
      if (c == 6) overrun_clr = 1'b1;
    end
    overrun_clr = 1'b0;

    // Reset in cycle 3 of a frame aborts it.
    for (int i = 0; i < 3; i++) set_voice(i, 2047, 255);
    voice_en = 3'b111;
    sample_tick = 1'b1;
    next_cycle();
    sample_tick = 1'b0;
    repeat (2) next_cycle();
    rst_n = 1'b0;
    #1;
    check("midrst voice_out", int'(voice_out != '0), 0);
    check("midrst mix", int'(mix_out), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst mul_wave", int'(mul_wave), 0);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      check("midrst no out_valid", int'(out_valid), 0);
    end

    // Back-to-back frames: second tick lands in DONE.
    sample_tick = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      sample_tick = (c == 5);
      check("b2b out_valid", int'(out_valid), (c == 5 || c == 10) ? 1 : 0);
      check("b2b overrun", int'(overrun), 0);
      if (c == 5 || c == 10) begin
        check("b2b v0", vout(0), 2039);
        check("b2b v2", vout(2), 2039);
        check("b2b mix", int'(mix_out), 6117);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/am_voice_scheduler.md
Name: am_voice_scheduler

Overview:
- Time-multiplexes one shared amplitude-modulator multiplier (12-bit signed wave × 8-bit unsigned envelope, one register stage) across NUM_VOICES voices.
- On each sample tick it does three things:
  - snapshots every voice's wave and envelope;
  - issues the snapshots to the multiplier round-robin, one per cycle;
  - collects the scaled results into per-voice output registers and a summed mix.
- Sits between the oscillator/envelope generators and the output filter/DAC stage.

Parameters:
- NUM_VOICES, 3, number of voices sharing the multiplier.
- MUL_LATENCY, 1, cycles from operands driven to mul_result valid.
- MIX_W, 14, mix width; must be ≥ 12 + clog2(NUM_VOICES).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle strobe that starts a frame.
- voice_en  in  NUM_VOICES  per-voice enable mask, sampled at tick.
- wave_in  in  NUM_VOICES×12  signed voice waveforms.
- env_in  in  NUM_VOICES×8  unsigned voice envelopes.
- mul_wave  out  12  signed operand to the shared multiplier.
- mul_env  out  8  unsigned operand to the shared multiplier.
- mul_result  in  12  signed multiplier output, (wave×env)>>>8.
- voice_out  out  NUM_VOICES×12  signed per-voice scaled results, held between frames.
- mix_out  out  MIX_W  signed sum of voice_out, held between frames.
- out_valid  out  1  one-cycle pulse when voice_out and mix_out update.
- busy  out  1  frame in progress.
- overrun  out  1  sticky flag: tick arrived while busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (async, rst_n low): every output is 0, FSM goes to IDLE, snapshot/accumulator/tag pipe are cleared. Takes effect immediately, mid-frame included; an aborted frame never produces out_valid.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: sample_tick=1 at the edge loads the snapshot regs with wave_in, env_in and voice_en. State goes to ISSUE, idx=0, acc=0.
- ISSUE: mul_wave=snap_wave[idx] and mul_env = snap_en[idx] ? snap_env[idx] : 0, both combinational from the snapshot. A tag {valid=1, idx} enters a MUL_LATENCY-deep shift pipe. idx increments each cycle; after idx=NUM_VOICES-1 the state goes to DRAIN.
- Outside ISSUE, mul_wave=0, mul_env=0 and the tag valid shifted in is 0.
- Result capture: when the pipe-output tag is valid, mul_result is written to voice_out_next[tag.idx] and sign-extended into acc (acc += result).
  - mul_result is ignored when the tag is invalid. The multiplier has no reset, so its post-reset contents are junk.
- DRAIN: lasts until the last tag exits the pipe, then goes to DONE. At that transition voice_out and mix_out load from the captured values and acc.
- DONE: out_valid=1 for exactly this cycle. It lasts one cycle, then returns to IDLE.
  - A sample_tick in DONE is accepted as if in IDLE; DONE and the new frame's snapshot share this cycle.
- Timing, with the tick in cycle 0:
  - ISSUE occupies cycles 1..N.
  - Results are captured in cycles 1+L..N+L.
  - out_valid is high in cycle N+L+1 (5 for defaults).
  - busy=1 in cycles 1..N+L; it is 0 in IDLE and DONE.
- sample_tick while busy=1: the tick is dropped, overrun is set, and the current frame is unaffected.
  - overrun_clr clears the flag. If clr and a new overrun event occur in the same cycle, the set wins.
- Input changes after the tick do not affect the frame in flight, because all values are snapshotted.
- Disabled voices are still issued, with env=0; the schedule length is fixed regardless of mask.
- Arithmetic: acc is MIX_W signed. The max magnitude is 3×2048, so no saturation is needed.

Decomposition:
- Shared package am_sched_pkg holds:
  - NUM_VOICES, WAVE_W=12, ENV_W=8 and the MIX_W default;
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - a typedef for the tag struct {logic valid; logic [$clog2(NUM_VOICES)-1:0] idx}.
- Sub-module am_sched_tag_pipe: a MUL_LATENCY-deep tag shift register with async clear.
- The shared am multiplier is instantiated alongside, outside this block.

Test Plan (bench models the multiplier as a 1-cycle register of (wave×env)>>>8, env unsigned):
- Reset with random inputs -> all outputs 0, busy=0; no out_valid until after the first tick.
- wave={100,-200,2047}, env={255,128,0}, en=111, tick at cycle 0 -> mul operands in cycles 1..3, voice_out={99,-100,0}, mix_out=-1, out_valid only in cycle 5.
- Same inputs with en=010 -> mul_env=0 in cycles 1 and 3, voice_out={0,-100,0}, mix_out=-100, out_valid still in cycle 5.
- Tick at cycle 0, extra tick at cycle 2, inputs changed in cycle 2 -> overrun=1 from cycle 3 until overrun_clr; frame results match the cycle-0 snapshot.
- rst_n low in cycle 3 of a frame -> outputs 0 immediately, no out_valid after release; next tick yields a normal frame with correct results.
- Ticks at cycles 0 and 5 with all wave=2047, env=255 -> no overrun, out_valid at cycles 5 and 10, voice_out=2039 each, mix_out=6117.
